// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer and control unit.
//   state_t : 4-bit multicycle state code seen by the control unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    HALT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC1  = 4'd3,
    EXEC2  = 4'd4
  } state_t;

endpackage

// File: rtl/cpu_state_sequencer_sat_counter.sv
// Saturating up-counter used for the sequencer's debug counters.
//   clk   : system clock
//   reset : synchronous active-high clear
//   inc   : count this cycle
//   count : current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_state_sequencer.sv
// Multicycle state sequencer: FETCH -> DECODE -> EXEC1 -> EXEC2, freezing
// on Avalon waitrequest while an access is outstanding, parking in HALT
// when the program jumps to address zero.
//   clk, reset    : clock and synchronous active-high reset
//   waitrequest   : Avalon slave stall
//   memread       : data read request (used in EXEC1)
//   memwrite      : data write request (used in EXEC2)
//   halt_req      : next PC is zero; decides HALT vs FETCH on EXEC2 exit
//   state         : current state code for the control unit
//   fetch_read    : instruction read strobe (whole of FETCH)
//   pc_write      : PC update pulse on the EXEC2 exit cycle
//   stall         : current state frozen by waitrequest
//   active        : not in HALT
//   cycle_count   : saturating count of non-HALT cycles
//   instr_count   : saturating count of retired instructions
module cpu_state_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest,
  input  logic             memread,
  input  logic             memwrite,
  input  logic             halt_req,
  output logic [3:0]       state,
  output logic             fetch_read,
  output logic             pc_write,
  output logic             stall,
  output logic             active,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_t state_q;
  state_t state_d;

  // Output decodes and next state. Stall freezes the state; waitrequest
  // only matters where an access is actually pending.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_read = 1'b0;
    stall      = 1'b0;
    pc_write   = 1'b0;
    active     = 1'b1;

    unique case (state_q)
      FETCH: begin
        fetch_read = 1'b1;
        stall      = waitrequest;
        if (!waitrequest) state_d = DECODE;
      end
      DECODE: begin
        state_d = EXEC1;
      end
      EXEC1: begin
        stall = memread & waitrequest;
        if (!stall) state_d = EXEC2;
      end
      EXEC2: begin
        stall = memwrite & waitrequest;
        if (!stall) begin
          // Pulse also fires when heading to HALT so the PC settles at 0.
          pc_write = 1'b1;
          state_d  = halt_req ? HALT : FETCH;
        end
      end
      HALT: begin
        active = 1'b0;
      end
      default: begin
        // Unreachable encodings recover to a clean fetch.
        state_d = FETCH;
      end
    endcase
  end

  // NOTE: reset is synchronous; only the control state and the counters
  // need it, there is no storage array here to clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (active),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_write),
    .count (instr_count)
  );

endmodule
